// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM encoding,
// response flag bit positions and the carry-update selection helper.
package alu_cmd_sequencer_pkg;

   localparam logic [3:0] OP_ADD       = 4'd1;
   localparam logic [3:0] OP_ADD_CARRY = 4'd2;
   localparam logic [3:0] OP_SUB       = 4'd3;
   localparam logic [3:0] OP_INC       = 4'd4;
   localparam logic [3:0] OP_DEC       = 4'd5;
   localparam logic [3:0] OP_AND       = 4'd6;
   localparam logic [3:0] OP_NOT       = 4'd7;
   localparam logic [3:0] OP_ROL       = 4'd8;
   localparam logic [3:0] OP_ROR       = 4'd9;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int FLG_CARRY   = 0;
   localparam int FLG_BORROW  = 1;
   localparam int FLG_ZERO    = 2;
   localparam int FLG_PARITY  = 3;
   localparam int FLG_INVALID = 4;
   localparam int NUM_FLAGS   = 5;

   // Additive ops latch carry-out, subtractive ops latch borrow, others keep the flag.
   function automatic logic next_carry(input logic [3:0] op, input logic cur,
                                       input logic carry_out, input logic borrow);
      logic r;
      case (op)
         OP_ADD, OP_ADD_CARRY, OP_INC: r = carry_out;
         OP_SUB, OP_DEC:               r = borrow;
         default:                      r = cur;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Sequences single commands through an external combinational ALU:
// accept (IDLE) -> one-cycle evaluate (EXEC) -> hold response (RESP).
module alu_cmd_sequencer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int BUS_WIDTH = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_opcode,
   input  logic [BUS_WIDTH-1:0] cmd_a,
   input  logic [BUS_WIDTH-1:0] cmd_b,
   input  logic                 cmd_use_acc,
   input  logic                 cmd_clr_carry,
   output logic [BUS_WIDTH-1:0] alu_a,
   output logic [BUS_WIDTH-1:0] alu_b,
   output logic [3:0]           alu_opcode,
   output logic                 alu_carry_in,
   input  logic [BUS_WIDTH-1:0] alu_y,
   input  logic                 alu_carry_out,
   input  logic                 alu_borrow,
   input  logic                 alu_zero,
   input  logic                 alu_parity,
   input  logic                 alu_invalid_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [BUS_WIDTH-1:0] rsp_y,
   output logic [NUM_FLAGS-1:0] rsp_flags,
   output logic [BUS_WIDTH-1:0] acc,
   output logic                 carry_flag,
   output logic [CNT_WIDTH-1:0] op_count,
   output logic [7:0]           err_count
);

   logic [1:0]           state_q, state_d;
   logic [BUS_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]           alu_op_q, alu_op_d;
   logic [BUS_WIDTH-1:0] acc_q, acc_d, rsp_y_q, rsp_y_d;
   logic                 carry_q, carry_d;
   logic [NUM_FLAGS-1:0] rsp_flags_q, rsp_flags_d, alu_flags_s;
   logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
   logic [7:0]           err_count_q, err_count_d;
   logic                 cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;

   // Pack the ALU status inputs into response flag order.
   always_comb begin
      alu_flags_s               = '0;
      alu_flags_s[FLG_CARRY]   = alu_carry_out;
      alu_flags_s[FLG_BORROW]  = alu_borrow;
      alu_flags_s[FLG_ZERO]    = alu_zero;
      alu_flags_s[FLG_PARITY]  = alu_parity;
      alu_flags_s[FLG_INVALID] = alu_invalid_op;
   end

   // Next-state and datapath updates for the three-phase command sequence.
   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      acc_d       = acc_q;
      carry_d     = carry_q;
      rsp_y_d     = rsp_y_q;
      rsp_flags_d = rsp_flags_q;
      op_count_d  = op_count_q;
      err_count_d = err_count_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               alu_op_d = cmd_opcode;
               alu_a_d  = cmd_use_acc ? acc_q : cmd_a;
               alu_b_d  = cmd_b;
               carry_d  = cmd_clr_carry ? 1'b0 : carry_q;
               state_d  = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            rsp_y_d     = alu_y;
            rsp_flags_d = alu_flags_s;
            if (!alu_invalid_op) begin
               acc_d   = alu_y;
               carry_d = next_carry(alu_op_q, carry_q, alu_carry_out, alu_borrow);
            end else if (err_count_q != 8'd255) begin
               err_count_d = err_count_q + 8'd1;
            end else begin
               err_count_d = err_count_q;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               op_count_d = op_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Handshake outputs are registered from the next state so they align with it.
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // State and output registers; reset drops any in-flight command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= 4'd0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         rsp_y_q     <= '0;
         rsp_flags_q <= '0;
         op_count_q  <= '0;
         err_count_q <= 8'd0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         rsp_y_q     <= rsp_y_d;
         rsp_flags_q <= rsp_flags_d;
         op_count_q  <= op_count_d;
         err_count_q <= err_count_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_opcode   = alu_op_q;
   assign alu_carry_in = carry_q;
   assign rsp_y        = rsp_y_q;
   assign rsp_flags    = rsp_flags_q;
   assign acc          = acc_q;
   assign carry_flag   = carry_q;
   assign op_count     = op_count_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: behavioural ALU on the alu_* port, scoreboard of
// expected responses, and architectural model of acc/carry/counters.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_use_acc, cmd_clr_carry;
   logic [3:0] cmd_opcode;
   logic [7:0] cmd_a, cmd_b;
   logic [7:0] alu_a, alu_b, alu_y;
   logic [3:0] alu_opcode;
   logic       alu_carry_in, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_y;
   logic [4:0] rsp_flags;
   logic [7:0] acc;
   logic       carry_flag;
   logic [15:0] op_count;
   logic [7:0] err_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_acc;
   logic       m_carry;
   int         m_err, m_ops;

   typedef struct packed {
      logic [7:0] y;
      logic [4:0] f;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.BUS_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_clr_carry(cmd_clr_carry),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_carry_in(alu_carry_in),
      .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_borrow(alu_borrow),
      .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_invalid_op(alu_invalid_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
      .acc(acc), .carry_flag(carry_flag), .op_count(op_count), .err_count(err_count)
   );

   // Reference ALU: returns {invalid, parity, zero, borrow, carry_out, y}.
   function automatic logic [12:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
      logic [8:0] t;
      logic [7:0] y;
      logic co, bo, inv;
      co = 1'b0; bo = 1'b0; inv = 1'b0; t = 9'd0; y = 8'd0;
      case (op)
         4'd1: begin t = {1'b0, a} + {1'b0, b}; y = t[7:0]; co = t[8]; end
         4'd2: begin t = {1'b0, a} + {1'b0, b} + {8'd0, cin}; y = t[7:0]; co = t[8]; end
         4'd3: begin y = a - b; bo = (a < b); end
         4'd4: begin t = {1'b0, a} + 9'd1; y = t[7:0]; co = t[8]; end
         4'd5: begin y = a - 8'd1; bo = (a == 8'd0); end
         4'd6: y = a & b;
         4'd7: y = ~a;
         4'd8: y = {a[6:0], a[7]};
         4'd9: y = {a[0], a[7:1]};
         default: begin y = 8'd0; inv = 1'b1; end
      endcase
      return {inv, ^y, (y == 8'd0), bo, co, y};
   endfunction

   assign {alu_invalid_op, alu_parity, alu_zero, alu_borrow, alu_carry_out, alu_y} =
          alu_fn(alu_opcode, alu_a, alu_b, alu_carry_in);

   task automatic do_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic use_acc, input logic clr, input int hold);
      int w;
      logic [7:0] opa;
      logic cin;
      logic [12:0] r;
      exp_t e;
      logic [7:0] y0;
      logic [4:0] f0;
      w = 0;
      while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
      checks++;
      if (!cmd_ready) begin errors++; $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready); end
      opa = use_acc ? m_acc : a;
      cin = clr ? 1'b0 : m_carry;
      r = alu_fn(op, opa, b, cin);
      e.y = r[7:0]; e.f = r[12:8];
      sb_q.push_back(e);
      m_carry = cin;
      if (!e.f[4]) begin
         m_acc = e.y;
         if (op == 4'd1 || op == 4'd2 || op == 4'd4) m_carry = e.f[0];
         else if (op == 4'd3 || op == 4'd5) m_carry = e.f[1];
      end else if (m_err != 255) begin
         m_err++;
      end
      cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
      cmd_use_acc = use_acc; cmd_clr_carry = clr;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_use_acc = ~use_acc; cmd_clr_carry = 1'b0;
      checks++;
      if (alu_a !== opa || alu_b !== b || alu_opcode !== op) begin
         errors++;
         $display("FAIL exec_operands: a=%h b=%h op=%0d required a=%h b=%h op=%0d", alu_a, alu_b, alu_opcode, opa, b, op);
      end
      checks++;
      if (alu_carry_in !== cin) begin errors++; $display("FAIL exec_carry_in: %b required %b", alu_carry_in, cin); end
      w = 1;
      while (!rsp_valid && w < 10) begin @(negedge clk); w++; end
      checks++;
      if (w != 2 || !rsp_valid) begin errors++; $display("FAIL rsp_latency: %0d cycles required 2", w); end
      y0 = rsp_y; f0 = rsp_flags;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_y !== y0 || rsp_flags !== f0 || rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || op_count !== m_ops[15:0]) begin
            errors++;
            $display("FAIL rsp_hold: y=%h f=%b v=%b rdy=%b cnt=%0d required y=%h f=%b v=1 rdy=0 cnt=%0d",
                     rsp_y, rsp_flags, rsp_valid, cmd_ready, op_count, y0, f0, m_ops[15:0]);
         end
      end
      e = sb_q.pop_front();
      checks++;
      if (rsp_y !== e.y || rsp_flags !== e.f) begin
         errors++;
         $display("FAIL rsp_data: op=%0d y=%h flags=%b required y=%h flags=%b", op, rsp_y, rsp_flags, e.y, e.f);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      m_ops++;
      checks++;
      if (acc !== m_acc || carry_flag !== m_carry) begin
         errors++;
         $display("FAIL arch_state: acc=%h carry=%b required acc=%h carry=%b", acc, carry_flag, m_acc, m_carry);
      end
      checks++;
      if (op_count !== m_ops[15:0] || err_count !== m_err[7:0]) begin
         errors++;
         $display("FAIL counters: ops=%0d errs=%0d required ops=%0d errs=%0d", op_count, err_count, m_ops[15:0], m_err[7:0]);
      end
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_handshake: v=%b rdy=%b required v=0 rdy=1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0;
      cmd_use_acc = 1'b0; cmd_clr_carry = 1'b0; rsp_ready = 1'b0;
      m_acc = 8'd0; m_carry = 1'b0; m_err = 0; m_ops = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || acc !== 8'd0 || carry_flag !== 1'b0 ||
          op_count !== 16'd0 || err_count !== 8'd0 || rsp_y !== 8'd0 || rsp_flags !== 5'd0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b v=%b acc=%h c=%b ops=%0d errs=%0d y=%h f=%b required all 0",
                  cmd_ready, rsp_valid, acc, carry_flag, op_count, err_count, rsp_y, rsp_flags);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: %b required 1", cmd_ready); end
   endtask

   task automatic test_add_carry();
      do_cmd(4'd1, 8'hF0, 8'h20, 1'b0, 1'b1, 0);
      checks++;
      if (acc !== 8'h10 || carry_flag !== 1'b1) begin errors++; $display("FAIL add_const: acc=%h c=%b required 10 1", acc, carry_flag); end
      do_cmd(4'd2, 8'h01, 8'h01, 1'b0, 1'b0, 0);
      checks++;
      if (acc !== 8'h03 || carry_flag !== 1'b0) begin errors++; $display("FAIL addc_const: acc=%h c=%b required 03 0", acc, carry_flag); end
   endtask

   task automatic test_sub_dec();
      do_cmd(4'd3, 8'h05, 8'h07, 1'b0, 1'b0, 0);
      checks++;
      if (acc !== 8'hFE || carry_flag !== 1'b1) begin errors++; $display("FAIL sub_const: acc=%h c=%b required FE 1", acc, carry_flag); end
      do_cmd(4'd5, 8'h00, 8'h00, 1'b0, 1'b1, 0);
      checks++;
      if (acc !== 8'hFF || carry_flag !== 1'b1) begin errors++; $display("FAIL dec_const: acc=%h c=%b required FF 1", acc, carry_flag); end
   endtask

   task automatic test_invalid();
      logic [3:0] bad;
      do_cmd(4'd6, 8'h3C, 8'hFF, 1'b0, 1'b0, 0);
      do_cmd(4'd0, 8'h12, 8'h34, 1'b0, 1'b0, 0);
      checks++;
      if (acc !== 8'h3C || err_count !== 8'd1) begin errors++; $display("FAIL invalid_const: acc=%h errs=%0d required 3C 1", acc, err_count); end
      for (int i = 0; i < 259; i++) begin
         bad = (i % 7 == 0) ? 4'd0 : 4'($urandom_range(10, 15));
         do_cmd(bad, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0);
      end
      checks++;
      if (err_count !== 8'hFF || acc !== 8'h3C) begin errors++; $display("FAIL err_saturate: errs=%h acc=%h required FF 3C", err_count, acc); end
   endtask

   task automatic test_rotate();
      do_cmd(4'd6, 8'h81, 8'hFF, 1'b0, 1'b0, 0);
      do_cmd(4'd8, 8'h00, 8'h00, 1'b1, 1'b0, 0);
      checks++;
      if (acc !== 8'h03) begin errors++; $display("FAIL rol1: acc=%h required 03", acc); end
      do_cmd(4'd8, 8'h00, 8'h00, 1'b1, 1'b0, 0);
      checks++;
      if (acc !== 8'h06) begin errors++; $display("FAIL rol2: acc=%h required 06", acc); end
   endtask

   task automatic test_backpressure();
      do_cmd(4'd4, 8'hFF, 8'h00, 1'b0, 1'b0, 5);
      do_cmd(4'd9, 8'h00, 8'h00, 1'b1, 1'b0, 3);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         do_cmd(4'($urandom_range(0, 11)), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_reset_exec();
      do_cmd(4'd6, 8'hA5, 8'hFF, 1'b0, 1'b0, 0);
      cmd_valid = 1'b1; cmd_opcode = 4'd1; cmd_a = 8'h77; cmd_b = 8'h99;
      cmd_use_acc = 1'b0; cmd_clr_carry = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (alu_opcode !== 4'd1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_exec: op=%0d rdy=%b required 1 0", alu_opcode, cmd_ready); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (acc !== 8'd0 || carry_flag !== 1'b0 || rsp_y !== 8'd0 || rsp_flags !== 5'd0 || alu_a !== 8'd0 ||
          alu_b !== 8'd0 || alu_opcode !== 4'd0 || op_count !== 16'd0 || err_count !== 8'd0 ||
          rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || alu_carry_in !== 1'b0) begin
         errors++;
         $display("FAIL reset_exec_zero: acc=%h c=%b y=%h f=%b a=%h b=%h op=%0d ops=%0d errs=%0d v=%b rdy=%b required all 0",
                  acc, carry_flag, rsp_y, rsp_flags, alu_a, alu_b, alu_opcode, op_count, err_count, rsp_valid, cmd_ready);
      end
      sb_q.delete();
      m_acc = 8'd0; m_carry = 1'b0; m_err = 0; m_ops = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_exec_ready: %b required 1", cmd_ready); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_exec_no_rsp: cycle %0d v=%b required 0", i, rsp_valid); end
      end
      do_cmd(4'd4, 8'h00, 8'h00, 1'b1, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_sub_dec();
      test_invalid();
      test_rotate();
      test_backpressure();
      test_back_to_back();
      test_reset_exec();
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left required 0", sb_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
